// File: rtl/sine_lut_scheduler.sv
// Two-channel sine sample scheduler sharing one quarter-wave ROM.
// Grants round-robin, folds each channel's phase onto 0..90 degrees and restores the sign.
module sine_lut_scheduler #(
    parameter int DATA_W    = 24,
    parameter int LUT_DEPTH = 91,
    parameter int ADDR_W    = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [8:0]               step0,
    input  logic [8:0]               step1,
    input  logic                     req0,
    input  logic                     req1,
    output logic                     valid0,
    output logic                     valid1,
    output logic signed [DATA_W-1:0] data0,
    output logic signed [DATA_W-1:0] data1,
    output logic [ADDR_W-1:0]        lut_addr,
    input  logic [DATA_W-1:0]        lut_data,
    output logic                     busy
);

    localparam int         QUARTER   = LUT_DEPTH - 1;
    localparam logic [8:0] STEP_MAX  = 9'd359;
    localparam logic [9:0] FULL_TURN = 10'd360;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_next;

    logic [8:0]  phase0, phase1;
    logic        rr_ptr;

    // Transaction context captured at grant, consumed in DATA
    logic        gnt_p1;
    logic [8:0]  step_p1;
    logic        neg_p1;

    logic        elig0, elig1, grant_any, grant_ch;
    logic [8:0]  grant_phase, grant_step_raw, grant_step;
    logic [ADDR_W-1:0] fold_addr;
    logic        fold_neg;
    logic [8:0]  cur_phase, phase_next;
    logic [9:0]  phase_sum;
    logic signed [DATA_W-1:0] sample;

    // Returns {negative, quarter-wave address} for a phase in 0..359
    function automatic logic [ADDR_W:0] fold_phase(input logic [8:0] p);
        int   pi;
        int   a;
        logic n;
        pi = {23'd0, p};
        if (pi < QUARTER) begin
            a = pi;
            n = 1'b0;
        end else if (pi < 2 * QUARTER) begin
            a = 2 * QUARTER - pi;
            n = 1'b0;
        end else if (pi < 3 * QUARTER) begin
            a = pi - 2 * QUARTER;
            n = 1'b1;
        end else begin
            a = 4 * QUARTER - pi;
            n = 1'b1;
        end
        return {n, a[ADDR_W-1:0]};
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                            input logic negative);
        return negative ? -$signed(mag) : $signed(mag);
    endfunction

    // Arbitration; a channel whose result is showing this cycle is masked
    always_comb begin
        elig0          = enable & req0 & ~valid0;
        elig1          = enable & req1 & ~valid1;
        grant_any      = elig0 | elig1;
        grant_ch       = (elig0 & elig1) ? rr_ptr : elig1;
        grant_phase    = grant_ch ? phase1 : phase0;
        grant_step_raw = grant_ch ? step1 : step0;
        grant_step     = (grant_step_raw > STEP_MAX) ? STEP_MAX : grant_step_raw;
        {fold_neg, fold_addr} = fold_phase(grant_phase);
    end

    always_comb begin
        cur_phase  = gnt_p1 ? phase1 : phase0;
        phase_sum  = {1'b0, cur_phase} + {1'b0, step_p1};
        phase_next = (phase_sum >= FULL_TURN) ? 9'(phase_sum - FULL_TURN) : phase_sum[8:0];
        sample     = apply_sign(lut_data, neg_p1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = grant_any ? ADDR : IDLE;
            ADDR:    state_next = DATA;
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Grant stage registers the address; DATA stage writes back the result
    always_ff @(posedge clk) begin
        if (reset) begin
            phase0   <= '0;
            phase1   <= '0;
            rr_ptr   <= 1'b0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            data0    <= '0;
            data1    <= '0;
            lut_addr <= '0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            if (state == IDLE && grant_any) begin
                gnt_p1   <= grant_ch;
                step_p1  <= grant_step;
                neg_p1   <= fold_neg;
                lut_addr <= fold_addr;
            end
            if (state == DATA) begin
                if (gnt_p1) begin
                    data1  <= sample;
                    valid1 <= 1'b1;
                    phase1 <= phase_next;
                end else begin
                    data0  <= sample;
                    valid0 <= 1'b1;
                    phase0 <= phase_next;
                end
                rr_ptr <= ~gnt_p1;
            end
        end
    end

endmodule

// File: tb/tb_sine_lut_scheduler.sv
// Directed bench for sine_lut_scheduler: transaction-level model checked every cycle,
// plus literal sample/timing expectations per scenario.
`timescale 1ns/1ps
module tb_sine_lut_scheduler;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [8:0]        step0 = '0;
    logic [8:0]        step1 = '0;
    logic              valid0, valid1, busy;
    logic [DATA_W-1:0] data0, data1;
    logic [DATA_W-1:0] lut_data = '0;
    logic [ADDR_W-1:0] lut_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sine_lut_scheduler #(.DATA_W(DATA_W), .LUT_DEPTH(91), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .step0(step0), .step1(step1), .req0(req0), .req1(req1),
        .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
        .lut_addr(lut_addr), .lut_data(lut_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM, lut[k] = k*1000
    always @(posedge clk) lut_data <= 24'(int'(lut_addr) * 1000);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Full-wave table from symmetry: sin(180-x)=sin(x), sin(x+180)=-sin(x)
    int wave[360];

    // Transaction-level model: a grant occupies the shared ROM for 3 cycles
    int       m_cnt = 0;
    int       m_ch = 0;
    int       m_step = 0;
    int       m_phase[2] = '{0, 0};
    int       m_rr = 0;
    bit [1:0] m_valid = '0;
    logic [23:0] m_data[2] = '{24'd0, 24'd0};
    bit       chk_on = 0;

    always @(posedge clk) begin
        bit       e0, e1;
        bit [1:0] nv;
        if (reset) begin
            m_cnt = 0; m_phase = '{0, 0}; m_rr = 0; m_valid = '0;
            m_data = '{24'd0, 24'd0}; chk_on = 1;
        end else begin
            nv = '0;
            if (m_cnt == 0) begin
                e0 = enable && req0 && !m_valid[0];
                e1 = enable && req1 && !m_valid[1];
                if (e0 || e1) begin
                    m_ch   = (e0 && e1) ? m_rr : (e0 ? 0 : 1);
                    m_step = (m_ch == 0) ? int'(step0) : int'(step1);
                    if (m_step > 359) m_step = 359;
                    m_cnt  = 2;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_data[m_ch]  = 24'(wave[m_phase[m_ch]]);
                    nv[m_ch]      = 1'b1;
                    m_phase[m_ch] = (m_phase[m_ch] + m_step) % 360;
                    m_rr          = 1 - m_ch;
                end
            end
            m_valid = nv;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid0", valid0, m_valid[0]);
            check("valid1", valid1, m_valid[1]);
            check("data0", data0, m_data[0]);
            check("data1", data1, m_data[1]);
            check("busy", busy, (m_cnt != 0));
        end
    end

    logic [23:0] cap0[$], cap1[$];
    int          order[$], vcyc0[$], vcyc1[$];

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            if (valid0 === 1'b1) begin cap0.push_back(data0); order.push_back(0); vcyc0.push_back(cyc); end
            if (valid1 === 1'b1) begin cap1.push_back(data1); order.push_back(1); vcyc1.push_back(cyc); end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap0.delete(); cap1.delete(); order.delete(); vcyc0.delete(); vcyc1.delete();
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; enable = 1'b1;
        tick(2);
        clear_caps();
    endtask

    task automatic wait_count(input int ch, input int n, input string name);
        int k;
        k = 0;
        while (((ch == 0) ? cap0.size() : cap1.size()) < n && k < 400) begin
            tick(1);
            k++;
        end
        check({name, "_count"}, (ch == 0) ? cap0.size() : cap1.size(), n);
    endtask

    initial begin
        int rel, addr_cyc;
        logic [23:0] exp1[5], exp2[5], exp3[5], exp4[3];
        exp1 = '{24'd0, 24'd1000, 24'd2000, 24'd3000, 24'd4000};
        exp2 = '{24'd0, 24'd90000, 24'd0, 24'hFEA070, 24'd0};
        exp3 = '{24'd0, 24'd80000, 24'hFFB1E0, 24'hFF15A0, 24'd40000};
        exp4 = '{24'd0, 24'hFFFC18, 24'hFFF830};

        for (int p = 0; p < 360; p++) begin
            if (p <= 90)       wave[p] = p * 1000;
            else if (p <= 180) wave[p] = wave[180 - p];
            else               wave[p] = -wave[p - 180];
        end
        check("model_w100", wave[100], 80000);
        check("model_w270", wave[270], -90000);
        check("model_w300", wave[300], -60000);

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_valid0", valid0, 0);
        check("rst_data0", data0, 0);
        check("rst_busy", busy, 0);
        check("rst_lut_addr", lut_addr, 0);

        // step0=1, req0 held; held request is masked while its result shows, so period is 4
        tick(1);
        reset = 1'b0; enable = 1'b1; step0 = 9'd1; req0 = 1'b1; rel = cyc;
        wait_count(0, 5, "t1");
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) check($sformatf("t1_d%0d", i), cap0[i], exp1[i]);
        check("t1_first_lat", vcyc0[0] - rel, 3);
        check("t1_period", vcyc0[1] - vcyc0[0], 4);
        check("t1_no_ch1", cap1.size(), 0);

        // step0=90: quadrant boundaries and wrap
        do_reset();
        reset = 1'b0; step0 = 9'd90; req0 = 1'b1;
        wait_count(0, 5, "t2");
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) check($sformatf("t2_d%0d", i), cap0[i], exp2[i]);

        // step0=100: all four quadrants
        do_reset();
        reset = 1'b0; step0 = 9'd100; req0 = 1'b1;
        wait_count(0, 5, "t3");
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) check($sformatf("t3_d%0d", i), cap0[i], exp3[i]);

        // step0=400 is clamped to 359
        do_reset();
        reset = 1'b0; step0 = 9'd400; req0 = 1'b1;
        wait_count(0, 3, "t3b");
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) check($sformatf("t3b_d%0d", i), cap0[i], exp4[i]);

        // Both channels: round-robin alternation
        do_reset();
        reset = 1'b0; step0 = 9'd1; step1 = 9'd2; req0 = 1'b1; req1 = 1'b1;
        wait_count(1, 3, "t4");
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("t4_order%0d", i), order[i], i % 2);
        check("t4_d1_0", cap1[0], 24'd0);
        check("t4_d1_1", cap1[1], 24'd2000);
        check("t4_d1_2", cap1[2], 24'd4000);
        check("t4_d0_1", cap0[1], 24'd1000);
        check("t4_period0", vcyc0[1] - vcyc0[0], 6);
        check("t4_period1", vcyc1[1] - vcyc1[0], 6);
        check("t4_offset", vcyc1[0] - vcyc0[0], 3);

        // Only req1 from reset: granted immediately
        do_reset();
        reset = 1'b0; req1 = 1'b1; rel = cyc;
        wait_count(1, 1, "t4b");
        req1 = 1'b0;
        check("t4b_lat", vcyc1[0] - rel, 3);

        // Reset during DATA of a ch0 transaction
        do_reset();
        reset = 1'b0; step0 = 9'd1; req0 = 1'b1;
        wait_count(0, 2, "t5_pre");
        tick(2);
        @(negedge clk);
        check("t5_busy_in_data", busy, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        clear_caps();
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_valid0", valid0, 0);
        check("t5_data0", data0, 0);
        wait_count(0, 2, "t5");
        req0 = 1'b0;
        check("t5_d0", cap0[0], 24'd0);
        check("t5_d1", cap0[1], 24'd1000);

        // enable dropped during ADDR
        do_reset();
        reset = 1'b0; step0 = 9'd1; step1 = 9'd2; req0 = 1'b1; req1 = 1'b1;
        tick(1);
        enable = 1'b0; addr_cyc = cyc;
        @(negedge clk);
        check("t6_busy_addr", busy, 1);
        tick(15);
        check("t6_one_valid", cap0.size(), 1);
        check("t6_no_ch1", cap1.size(), 0);
        check("t6_lat", vcyc0[0] - addr_cyc, 2);
        check("t6_idle", busy, 0);
        enable = 1'b1;
        wait_count(0, 2, "t6");
        req0 = 1'b0; req1 = 1'b0;
        check("t6_resume_ch1_first", order[1], 1);
        check("t6_ch1_d", cap1[0], 24'd0);
        check("t6_ch0_d", cap0[1], 24'd1000);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
